// File: rtl/pwr_fault_monitor.sv
// Rail enable gate: latches ramp-timeout / PWRGD-dropout faults, then sheds rails
// top-down on a ms timer. Optional auto-retry from FLT: PWR_FAULT_AUTO_RETRY_EN.
module pwr_fault_monitor #(
  parameter int NUM_RAILS = 4,
  parameter int CNT_W = 11,
  parameter logic [CNT_W-1:0] TIMEOUT_MS = 11'd50,
`ifdef PWR_FAULT_AUTO_RETRY_EN
  parameter logic [CNT_W-1:0] RETRY_MS = 11'd100,
`endif
  parameter logic [CNT_W-1:0] OFF_DELAY_MS = 11'd2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 ms_pulse,
  input  logic [NUM_RAILS-1:0] rail_en_req,
  input  logic [NUM_RAILS-1:0] rail_pwrgd,
  input  logic                 clr_fault,
  output logic [NUM_RAILS-1:0] rail_en_out,
  output logic                 fault,
  output logic [NUM_RAILS-1:0] fault_rail,
  output logic [1:0]           fault_code
);

  typedef enum logic [1:0] {
    MON  = 2'd0,
    SHDN = 2'd1,
    FLT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_RAILS-1:0] en_q, en_d;
  logic [NUM_RAILS-1:0] keep_q, keep_d;
  logic [NUM_RAILS-1:0] frail_q, frail_d;
  logic [NUM_RAILS-1:0] seen_q, seen_d;
  logic [NUM_RAILS-1:0] to_hit, drop_hit;
  logic [NUM_RAILS-1:0] keep_top;
  logic [1:0]           code_q, code_d;
  logic                 fault_q;
  logic [CNT_W-1:0]     tcnt_q [NUM_RAILS];
  logic [CNT_W-1:0]     tcnt_d [NUM_RAILS];
  logic [CNT_W-1:0]     offcnt_q, offcnt_d;
  logic                 clr_ok;
  logic                 exit_flt;

  assign clr_ok = clr_fault & ~(|rail_en_req);

`ifdef PWR_FAULT_AUTO_RETRY_EN
  logic [CNT_W-1:0] retry_q, retry_d;

  always_comb begin
    retry_d = '0;
    if (state_q == FLT && rail_en_req == '0) begin
      retry_d = retry_q;
      if (ms_pulse && retry_q != RETRY_MS)
        retry_d = retry_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) retry_q <= '0;
    else         retry_q <= retry_d;
  end

  assign exit_flt = clr_ok |
    ((retry_q == RETRY_MS) & ~(|rail_en_req));
`else
  assign exit_flt = clr_ok;
`endif

  always_comb begin
    for (int i = 0; i < NUM_RAILS; i++) begin
      tcnt_d[i] = tcnt_q[i];
      if (!rail_en_req[i] || rail_pwrgd[i])
        tcnt_d[i] = '0;
      else if (ms_pulse && tcnt_q[i] != TIMEOUT_MS)
        tcnt_d[i] = tcnt_q[i] + 1'b1;
      seen_d[i]   = rail_en_req[i] & (seen_q[i] | rail_pwrgd[i]);
      to_hit[i]   = (tcnt_q[i] == TIMEOUT_MS);
      drop_hit[i] = rail_en_req[i] & seen_q[i] & ~rail_pwrgd[i];
    end
  end

  // one-hot of the highest rail still kept on
  always_comb begin
    keep_top = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      if (keep_q[i]) begin
        keep_top    = '0;
        keep_top[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    keep_d   = keep_q;
    offcnt_d = offcnt_q;
    frail_d  = frail_q;
    code_d   = code_q;
    unique case (state_q)
      MON: begin
        en_d     = rail_en_req;
        offcnt_d = '0;
        if (|(to_hit | drop_hit)) begin
          frail_d = to_hit | drop_hit;
          code_d  = (|drop_hit) ? 2'b10 : 2'b01;
          keep_d  = {1'b0, {(NUM_RAILS-1){1'b1}}};
          state_d = SHDN;
        end
      end
      SHDN: begin
        en_d = rail_en_req & keep_q;
        if (keep_q == '0) begin
          state_d = FLT;
        end else if (ms_pulse) begin
          if (offcnt_q == OFF_DELAY_MS - 1'b1) begin
            keep_d   = keep_q & ~keep_top;
            offcnt_d = '0;
          end else begin
            offcnt_d = offcnt_q + 1'b1;
          end
        end
      end
      FLT: begin
        en_d = '0;
        if (exit_flt) begin
          state_d = MON;
          frail_d = '0;
          code_d  = 2'b00;
        end
      end
      default: begin
        en_d    = '0;
        state_d = MON;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= MON;
      en_q     <= '0;
      keep_q   <= '0;
      frail_q  <= '0;
      seen_q   <= '0;
      code_q   <= 2'b00;
      fault_q  <= 1'b0;
      offcnt_q <= '0;
      for (int i = 0; i < NUM_RAILS; i++)
        tcnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      keep_q   <= keep_d;
      frail_q  <= frail_d;
      seen_q   <= seen_d;
      code_q   <= code_d;
      fault_q  <= (state_d != MON);
      offcnt_q <= offcnt_d;
      for (int i = 0; i < NUM_RAILS; i++)
        tcnt_q[i] <= tcnt_d[i];
    end
  end

  assign rail_en_out = en_q;
  assign fault       = fault_q;
  assign fault_rail  = frail_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_pwr_fault_monitor.sv
// Scoreboarded bench for pwr_fault_monitor: directed scenarios plus
// randomized rails, checked against a rail-level behavioural model.
module tb_pwr_fault_monitor;
  localparam int NR    = 4;
  localparam int TO    = 50;
  localparam int OFFD  = 2;
  localparam int RETRY = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          ms;
  logic [NR-1:0] req;
  logic [NR-1:0] pg;
  logic          clr;
  logic [NR-1:0] en_o;
  logic          fault_o;
  logic [NR-1:0] frail_o;
  logic [1:0]    code_o;

  always #5 clk = ~clk;

  pwr_fault_monitor dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .ms_pulse   (ms),
    .rail_en_req(req),
    .rail_pwrgd (pg),
    .clr_fault  (clr),
    .rail_en_out(en_o),
    .fault      (fault_o),
    .fault_rail (frail_o),
    .fault_code (code_o)
  );

  typedef struct packed {
    logic [NR-1:0] en;
    logic          f;
    logic [NR-1:0] fr;
    logic [1:0]    code;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cycn  = 0;

  // model: mode 0 monitoring, 1 shedding, 2 faulted
  int   m_mode;
  int   m_kept;
  int   m_since;
  int   m_retry;
  int   m_ramp[NR];
  bit   m_seen[NR];
  exp_t m_out;

  int pulses  = 0;
  int div     = 0;
  bit rand_ms = 0;

  function automatic void model_step();
    logic [NR-1:0] hits;
    bit any_dr;
    bit leave;
    if (rst) begin
      m_mode = 0; m_kept = 0; m_since = 0; m_retry = 0;
      for (int i = 0; i < NR; i++) begin
        m_ramp[i] = 0; m_seen[i] = 0;
      end
      m_out = '0;
      sbq.push_back(m_out);
      return;
    end
    hits = '0;
    any_dr = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_ramp[i] == TO) hits[i] = 1'b1;
      if (req[i] && m_seen[i] && !pg[i]) begin
        hits[i] = 1'b1;
        any_dr = 1;
      end
    end
    case (m_mode)
      0: begin
        m_out.en = req;
        if (hits != 0) begin
          m_out.fr   = hits;
          m_out.code = any_dr ? 2'd2 : 2'd1;
          m_kept = NR - 1;
          m_since = 0;
          m_mode = 1;
        end
      end
      1: begin
        m_out.en = req & NR'((1 << m_kept) - 1);
        if (m_kept == 0) m_mode = 2;
        else if (ms) begin
          m_since++;
          if (m_since == OFFD) begin
            m_kept--;
            m_since = 0;
          end
        end
      end
      default: begin
        m_out.en = '0;
        leave = clr && (req == 0);
`ifdef PWR_FAULT_AUTO_RETRY_EN
        if (m_retry >= RETRY && req == 0) leave = 1;
        if (req != 0) m_retry = 0;
        else if (ms && m_retry < RETRY) m_retry++;
`endif
        if (leave) begin
          m_mode = 0;
          m_out.fr = '0;
          m_out.code = 2'd0;
        end
      end
    endcase
    if (m_mode != 2) m_retry = 0;
    m_out.f = (m_mode != 0);
    for (int i = 0; i < NR; i++) begin
      if (!req[i] || pg[i]) m_ramp[i] = 0;
      else if (ms && m_ramp[i] < TO) m_ramp[i]++;
      if (!req[i]) m_seen[i] = 0;
      else if (pg[i]) m_seen[i] = 1;
    end
    sbq.push_back(m_out);
  endfunction

  task automatic cyc();
    if (rand_ms) ms = ($urandom_range(3) == 0);
    else begin
      ms = (div == 3);
      div = (div + 1) % 4;
    end
    if (ms) pulses++;
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_ms(input int n);
    int p0;
    p0 = pulses;
    while (pulses - p0 < n) cyc();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycn++;
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        tests++;
        if ({en_o, fault_o, frail_o, code_o} !== e) begin
          fails++;
          $display("FAIL sb cyc %0d: got en=%b f=%b fr=%b c=%b expected en=%b f=%b fr=%b c=%b",
                   cycn, en_o, fault_o, frail_o, code_o,
                   e.en, e.f, e.fr, e.code);
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] stuck;
    int guard;
    rst = 1'b1; ms = 1'b0; req = '0; pg = '0; clr = 1'b0;
    @(negedge clk);

    run(3);
    chk("rst_en", en_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_frail", frail_o, 0);
    chk("rst_code", code_o, 0);
    rst = 1'b0;
    run(2);

    for (int k = 0; k < NR; k++) begin
      req[k] = 1'b1;
      run_ms(3);
      pg[k] = 1'b1;
      run_ms(3);
    end
    run_ms(5);
    chk("ramp_en", en_o, 4'b1111);
    chk("ramp_fault", fault_o, 0);

    pg[2] = 1'b0;
    run(2);
    chk("drop_code", code_o, 2);
    chk("drop_frail", frail_o, 4'b0100);
    chk("drop_en", en_o, 4'b0111);
    run_ms(8);
    run(2);
    chk("drop_flt_en", en_o, 0);
    chk("drop_flt_f", fault_o, 1);

    req = 4'b0001; clr = 1'b1;
    run(5);
    chk("clr_busy", fault_o, 1);
    req = '0;
    run(1);
    clr = 1'b0;
    chk("clr_fault", fault_o, 0);
    chk("clr_frail", frail_o, 0);
    chk("clr_code", code_o, 0);
    pg = '0;
    run(2);

    req = 4'b0001;
    run_ms(TO);
    chk("to_edge", fault_o, 0);
    run(1);
    chk("to_fault", fault_o, 1);
    chk("to_code", code_o, 1);
    chk("to_frail", frail_o, 4'b0001);
    run_ms(8);
    run(2);
    chk("to_en", en_o, 0);
    req = '0; clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(2);

    req = 4'b1111; pg = 4'b0111;
    run_ms(TO);
    pg = 4'b0101;
    run(2);
    chk("sim_frail", frail_o, 4'b1010);
    chk("sim_code", code_o, 2);
    run_ms(8);
    run(2);
    req = '0; pg = '0; clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(2);

    req = 4'b0001; pg = 4'b0001;
    run_ms(2);
    pg = '0;
    run(1);
    run_ms(8);
    run(2);
    req = '0;
    run_ms(RETRY);
    run(2);
`ifdef PWR_FAULT_AUTO_RETRY_EN
    chk("retry_fault", fault_o, 0);
`else
    chk("retry_fault", fault_o, 1);
`endif
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    run(2);

    req = 4'b1111; pg = 4'b1111;
    run(3);
    pg = 4'b1011;
    guard = 0;
    while (en_o != 4'b0011 && guard < 400) begin
      run(1);
      guard++;
    end
    chk("shdn_reach", en_o, 4'b0011);
    rst = 1'b1;
    run(1);
    chk("mid_rst_en", en_o, 0);
    chk("mid_rst_f", fault_o, 0);
    chk("mid_rst_fr", frail_o, 0);
    chk("mid_rst_c", code_o, 0);
    rst = 1'b0;
    req = 4'b0110; pg = 4'b0110;
    run(2);
    chk("post_rst_en", en_o, 4'b0110);

    rand_ms = 1;
    repeat (10) begin
      stuck = NR'($urandom) & NR'($urandom);
      repeat (400) begin
        if ($urandom_range(29) == 0) req = NR'($urandom);
        if ($urandom_range(59) == 0) req = '0;
        if ($urandom_range(5) == 0) pg = req & ~stuck;
        if ($urandom_range(39) == 0) pg = NR'($urandom);
        clr = ($urandom_range(9) == 0);
        rst = ($urandom_range(499) == 0);
        cyc();
      end
    end
    rst = 1'b0; clr = 1'b0;
    run(3);

    @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwr_fault_monitor.md
Name: pwr_fault_monitor

Overview:
- Sits between the power-sequencing timer chain and the rail-enable pins.
- Consumes the sequencer's per-rail enable requests and the rail PWRGD inputs, and forwards the enables to the pins.
- Detects rail ramp timeouts and PWRGD dropouts, latches the fault, then performs a reverse-order timed shutdown.
- Holds all rails off until the fault is cleared.

Parameters:
- NUM_RAILS, 4: number of rails; bit 0 is the first rail enabled.
- CNT_W, 11: width of all ms counters (matches the ms timer width).
- TIMEOUT_MS, 11'd50: ms pulses allowed from enable until PWRGD.
- OFF_DELAY_MS, 11'd2: ms pulses between successive rail turn-offs; must be ≥1.
- RETRY_MS, 11'd100: idle time before auto-clear; used only with the optional feature.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- sys_rst  in  1  synchronous, active-high reset.
- ms_pulse  in  1  one-cycle tick, once per ms, from the 1 ms timer.
- rail_en_req  in  NUM_RAILS  enable requests from the sequencer timers.
- rail_pwrgd  in  NUM_RAILS  rail power-good; already synchronized/deglitched upstream.
- clr_fault  in  1  fault clear request (level, sampled each cycle).
- rail_en_out  out  NUM_RAILS  registered enables to the rail pins.
- fault  out  1  high in SHDN and FLT.
- fault_rail  out  NUM_RAILS  latched mask of the rails that faulted.
- fault_code  out  2  00 none, 01 ramp timeout, 10 PWRGD dropout.

Behaviour:
- Reset values: all outputs 0; state MON; all counters and masks 0.
- Reset applies at any time, including mid-SHDN; outputs are 0 at the first edge with sys_rst=1.
- Per-rail ramp counter tcnt[i]:
  - Cleared when rail_en_req[i]=0 or rail_pwrgd[i]=1.
  - Otherwise increments on ms_pulse and saturates at TIMEOUT_MS.
  - to_hit[i] = (tcnt[i]==TIMEOUT_MS).
- Per-rail pg_seen[i]:
  - Set when rail_en_req[i]&rail_pwrgd[i].
  - Cleared when rail_en_req[i]=0.
  - drop_hit[i] = rail_en_req[i] & pg_seen[i] & ~rail_pwrgd[i].
- MON state:
  - rail_en_out <= rail_en_req (one-cycle latency).
  - If any to_hit or drop_hit:
    - fault_rail <= to_hit|drop_hit.
    - fault_code <= 10 if any drop_hit, else 01 (dropout has priority).
    - keep <= all-ones with bit NUM_RAILS-1 cleared; offcnt <= 0; go to SHDN.
- SHDN state:
  - rail_en_out <= rail_en_req & keep.
  - offcnt increments on ms_pulse.
  - When ms_pulse and offcnt==OFF_DELAY_MS-1: clear the highest set bit of keep and set offcnt <= 0.
  - When keep==0, go to FLT on the next edge.
  - New faults are ignored; the first fault record is kept.
  - If the sequencer drops a request, that rail turns off immediately.
- FLT state:
  - rail_en_out <= 0; fault=1; fault_rail and fault_code hold.
  - clr_fault with rail_en_req==0: go to MON and clear fault, fault_rail and fault_code (fault_code to 00) on the same edge.
  - clr_fault with rail_en_req!=0: ignored.
- fault is registered and equals (state!=MON).
- Simultaneous ms_pulse and fault entry: the offcnt reset wins.

Optional Feature:
- Macro PWR_FAULT_AUTO_RETRY_EN.
- Defined:
  - In FLT, a retry counter increments on ms_pulse while rail_en_req==0; it clears whenever rail_en_req!=0.
  - When it reaches RETRY_MS, the block clears the fault and enters MON exactly as clr_fault would.
  - clr_fault still works.
- Undefined: the retry counter is not built; only clr_fault exits FLT.

Test Plan:
- Normal ramp (TIMEOUT_MS=50): set rail_en_req bits 0..3 one per 6 ms; PWRGD rises 3 ms after each -> fault stays 0; rail_en_out tracks rail_en_req one cycle late; final value 4'b1111.
- Ramp timeout: rail_en_req=4'b0001, rail_pwrgd=0 for 50 ms pulses -> one cycle after the 50th pulse's edge, fault=1, fault_code=01, fault_rail=0001; rail_en_out=0000 (bit 0 cleared by the final step); state reaches FLT after 3 steps of 2 ms.
- Dropout, rails at 1111: drop rail_pwrgd[2] -> fault_code=10, fault_rail=0100; rail_en_out sequence 0111, then 0011 after 2 ms, 0001 after 4 ms, 0000 after 6 ms; FLT next cycle.
- Simultaneous faults: timeout on rail 3 and dropout on rail 1 in the same cycle -> fault_rail=1010, fault_code=10.
- Clear in FLT:
  - clr_fault=1 with rail_en_req=0001 -> no change.
  - Then rail_en_req=0000 with clr_fault=1 -> next edge fault=0, fault_rail=0, fault_code=00, state MON.
  - With the macro and no clr_fault: 100 ms of rail_en_req=0 produces the same result.
- Reset mid-SHDN: sys_rst=1 while rail_en_out=0011 -> next edge all outputs 0; after release, rail_en_out follows rail_en_req.
